// File: rtl/syscall_if.sv
// syscall_if: syscall decode inputs, go button and display/status outputs
interface syscall_if #(parameter int CNT_W = 32);
  logic syscall;
  logic [31:0] v0;
  logic [31:0] a0;
  logic go_btn;
  logic show;
  logic go;
  logic halted;
  logic [31:0] disp_data;
  logic disp_valid;
  logic [CNT_W-1:0] syscall_cnt;
  modport master(output syscall, v0, a0, go_btn, input show, go, halted, disp_data, disp_valid, syscall_cnt);
  modport slave(input syscall, v0, a0, go_btn, output show, go, halted, disp_data, disp_valid, syscall_cnt);
endinterface

// File: rtl/syscall_unit.sv
// syscall_unit: syscall halt/display decode, debounced go pulse and syscall counter
module syscall_unit #(
  parameter logic [31:0] HALT_CODE = 32'd10,
  parameter logic [31:0] SHOW_CODE = 32'd34,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  syscall_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, nxt;
  logic [1:0] sync;
  logic level;
  logic [DW-1:0] db_cnt;
  logic accept, diff, flip;
  assign bus.show = bus.syscall & (bus.v0 != HALT_CODE);
  assign accept = (state == RUN) & bus.syscall;
  assign diff = sync[1] != level;
  assign flip = diff & (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  // go overrides a same-cycle halt request, matching the downstream halt register
  always_comb nxt = state == HALT ? (bus.go ? RUN : HALT) : (accept && bus.v0 == HALT_CODE && !bus.go ? HALT : RUN);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      sync <= '0;
      level <= 1'b0;
      db_cnt <= '0;
      bus.go <= 1'b0;
      bus.halted <= 1'b0;
      bus.disp_data <= '0;
      bus.disp_valid <= 1'b0;
      bus.syscall_cnt <= '0;
    end else begin
      state <= nxt;
      bus.halted <= nxt == HALT;
      sync <= {sync[0], bus.go_btn};
      db_cnt <= diff && !flip ? db_cnt + 1'b1 : '0;
      level <= flip ? sync[1] : level;
      bus.go <= flip & sync[1];
      bus.syscall_cnt <= accept ? bus.syscall_cnt + CNT_W'(1) : bus.syscall_cnt;
      bus.disp_data <= accept && bus.v0 == SHOW_CODE ? bus.a0 : bus.disp_data;
      bus.disp_valid <= bus.disp_valid | (accept && bus.v0 == SHOW_CODE);
    end
  end
endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: directed and randomized checks of syscall_unit against a behavioural model
module tb_syscall_unit;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  syscall_if #(.CNT_W(32)) bus();
  syscall_if #(.CNT_W(4)) bus4();
  syscall_unit dut (.clk(clk), .rst(rst), .bus(bus));
  syscall_unit #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  int checks = 0;
  int errors = 0;
  logic m_halt, m_go, m_level, m_valid, p1, p2, all_diff;
  logic [31:0] m_cnt, m_data;
  bit win[$];
  // reference: level flips once the last 16 synchronised samples all disagree with it
  always @(posedge clk) begin
    if (rst) begin
      m_halt = 0; m_go = 0; m_level = 0; m_valid = 0; p1 = 0; p2 = 0;
      m_cnt = 0; m_data = 0; win.delete();
    end else begin
      if (!m_halt && bus.syscall) begin
        m_cnt++;
        if (bus.v0 == 34) begin m_data = bus.a0; m_valid = 1; end
        if (bus.v0 == 10 && !m_go) m_halt = 1;
      end else if (m_halt && m_go) m_halt = 0;
      win.push_back(p2);
      p2 = p1;
      p1 = bus.go_btn;
      if (win.size() > 16) void'(win.pop_front());
      all_diff = 1;
      foreach (win[i]) if (win[i] == m_level) all_diff = 0;
      m_go = 0;
      if (win.size() == 16 && all_diff) begin
        m_level = ~m_level;
        m_go = m_level;
        win.delete();
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end
  task automatic test_reset();
    int first;
    rst = 1; bus.go_btn = 1; bus.syscall = 1; bus.v0 = 34; bus.a0 = 32'h12345678;
    bus4.go_btn = 0; bus4.syscall = 1; bus4.v0 = 34; bus4.a0 = 32'h1;
    repeat (2) @(negedge clk);
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", bus.halted); end
    checks++; if (bus.go !== 1'b0) begin errors++; $display("FAIL reset_go: got %b exp 0", bus.go); end
    checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid: got %b exp 0", bus.disp_valid); end
    checks++; if (bus.disp_data !== 32'h0) begin errors++; $display("FAIL reset_disp_data: got %h exp 0", bus.disp_data); end
    checks++; if (bus.syscall_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", bus.syscall_cnt); end
    checks++; if (bus4.syscall_cnt !== 4'h0) begin errors++; $display("FAIL reset_cnt4: got %0d exp 0", bus4.syscall_cnt); end
    rst = 0; bus.syscall = 0; bus4.syscall = 0;
    first = 0;
    for (int n = 1; n <= 40 && first == 0; n++) begin
      @(negedge clk);
      if (bus.go === 1'b1) first = n;
    end
    checks++; if (first < 18 || first > 19) begin errors++; $display("FAIL reset_go_latency: got %0d cycles exp 18", first); end
    bus.go_btn = 0;
    repeat (25) @(negedge clk);
    checks++; if (bus.halted !== 1'b0 || bus.syscall_cnt !== 32'h0) begin errors++; $display("FAIL reset_go_no_effect: halted %b cnt %0d exp 0 0", bus.halted, bus.syscall_cnt); end
  endtask
  task automatic test_display();
    logic [31:0] base = m_cnt;
    bus.syscall = 1; bus.v0 = 34; bus.a0 = 32'hDEADBEEF;
    #1;
    checks++; if (bus.show !== 1'b1) begin errors++; $display("FAIL display_show: got %b exp 1", bus.show); end
    @(negedge clk);
    bus.syscall = 0; bus.v0 = 0;
    checks++; if (bus.disp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL display_data: got %h exp deadbeef", bus.disp_data); end
    checks++; if (bus.disp_valid !== 1'b1) begin errors++; $display("FAIL display_valid: got %b exp 1", bus.disp_valid); end
    checks++; if (bus.syscall_cnt !== base + 1) begin errors++; $display("FAIL display_cnt: got %0d exp %0d", bus.syscall_cnt, base + 1); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL display_halted: got %b exp 0", bus.halted); end
  endtask
  task automatic test_halt_resume();
    logic [31:0] base = m_cnt;
    logic [31:0] data = m_data;
    int seen = 0;
    int extra = 0;
    bus.syscall = 1; bus.v0 = 10; bus.a0 = $urandom;
    for (int i = 0; i < 50; i++) begin
      #1;
      checks++; if (bus.show !== 1'b0) begin errors++; $display("FAIL halt_show: got %b exp 0", bus.show); end
      @(negedge clk);
      checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_halted: cycle %0d got %b exp 1", i, bus.halted); end
      checks++; if (bus.syscall_cnt !== base + 1) begin errors++; $display("FAIL halt_cnt: cycle %0d got %0d exp %0d", i, bus.syscall_cnt, base + 1); end
    end
    checks++; if (bus.disp_data !== data) begin errors++; $display("FAIL halt_disp_data: got %h exp %h", bus.disp_data, data); end
    bus.go_btn = 1;
    for (int n = 1; n <= 40 && seen == 0; n++) begin
      @(negedge clk);
      if (bus.go === 1'b1) seen = n;
    end
    checks++; if (seen < 18 || seen > 19) begin errors++; $display("FAIL resume_go_latency: got %0d cycles exp 18", seen); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL resume_halted_during_go: got %b exp 1", bus.halted); end
    @(negedge clk);
    bus.syscall = 0;
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL resume_halted: got %b exp 0", bus.halted); end
    checks++; if (bus.syscall_cnt !== base + 1) begin errors++; $display("FAIL resume_cnt: got %0d exp %0d", bus.syscall_cnt, base + 1); end
    for (int n = 0; n < 30; n++) begin @(negedge clk); if (bus.go === 1'b1) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL resume_hold_pulses: got %0d exp 0", extra); end
    bus.go_btn = 0;
    repeat (30) @(negedge clk);
  endtask
  task automatic test_simultaneous();
    logic [31:0] base = m_cnt;
    int seen = 0;
    bus.go_btn = 1;
    for (int n = 1; n <= 40 && seen == 0; n++) begin
      @(negedge clk);
      if (bus.go === 1'b1) seen = n;
    end
    checks++; if (seen == 0) begin errors++; $display("FAIL simul_go_seen: got none exp pulse"); end
    bus.syscall = 1; bus.v0 = 10; bus.a0 = $urandom;
    @(negedge clk);
    bus.syscall = 0;
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL simul_halted: got %b exp 0", bus.halted); end
    checks++; if (bus.syscall_cnt !== base + 1) begin errors++; $display("FAIL simul_cnt: got %0d exp %0d", bus.syscall_cnt, base + 1); end
    bus.go_btn = 0;
    repeat (25) @(negedge clk);
  endtask
  task automatic test_debounce();
    int pulses = 0;
    int first = 0;
    for (int i = 0; i < 100; i++) begin
      bus.go_btn = ((i / 5) % 2) == 0;
      @(negedge clk);
      if (bus.go === 1'b1) pulses++;
      checks++; if (bus.go !== m_go) begin errors++; $display("FAIL bounce_go_model: cycle %0d got %b exp %b", i, bus.go, m_go); end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL bounce_pulses: got %0d exp 0", pulses); end
    bus.go_btn = 1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.go === 1'b1) begin pulses++; if (first == 0) first = n; end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL hold_pulses: got %0d exp 1", pulses); end
    checks++; if (first < 17 || first > 19) begin errors++; $display("FAIL hold_latency: got %0d cycles exp 18", first); end
    bus.go_btn = 0; pulses = 0;
    for (int n = 0; n < 40; n++) begin @(negedge clk); if (bus.go === 1'b1) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL release_pulses: got %0d exp 0", pulses); end
  endtask
  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin bus.go_btn = 1'($urandom_range(0, 1)); hold = $urandom_range(1, 30); end
      hold--;
      bus.a0 = $urandom;
      if (m_halt) begin bus.syscall = 1; bus.v0 = 10; end
      else begin
        bus.syscall = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: bus.v0 = 10;
          1: bus.v0 = 34;
          2: bus.v0 = $urandom_range(0, 63);
          default: bus.v0 = $urandom;
        endcase
      end
      #1;
      checks++; if (bus.show !== (bus.syscall && bus.v0 != 10)) begin errors++; $display("FAIL rand_show: cycle %0d got %b", i, bus.show); end
      @(negedge clk);
      checks++; if (bus.halted !== m_halt) begin errors++; $display("FAIL rand_halted: cycle %0d got %b exp %b", i, bus.halted, m_halt); end
      checks++; if (bus.go !== m_go) begin errors++; $display("FAIL rand_go: cycle %0d got %b exp %b", i, bus.go, m_go); end
      checks++; if (bus.syscall_cnt !== m_cnt) begin errors++; $display("FAIL rand_cnt: cycle %0d got %0d exp %0d", i, bus.syscall_cnt, m_cnt); end
      checks++; if (bus.disp_data !== m_data || bus.disp_valid !== m_valid) begin errors++; $display("FAIL rand_disp: cycle %0d got %h/%b exp %h/%b", i, bus.disp_data, bus.disp_valid, m_data, m_valid); end
    end
    bus.syscall = 0;
  endtask
  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      bus4.syscall = 1; bus4.v0 = 1; bus4.a0 = $urandom;
      #1;
      checks++; if (bus4.show !== 1'b1) begin errors++; $display("FAIL wrap_show: cycle %0d got %b exp 1", i, bus4.show); end
      @(negedge clk);
    end
    bus4.syscall = 0;
    checks++; if (bus4.syscall_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt: got %0d exp 1", bus4.syscall_cnt); end
    checks++; if (bus4.disp_valid !== 1'b0) begin errors++; $display("FAIL wrap_disp_valid: got %b exp 0", bus4.disp_valid); end
  endtask
  initial begin
    bus.syscall = 0; bus.v0 = 0; bus.a0 = 0; bus.go_btn = 0;
    bus4.syscall = 0; bus4.v0 = 0; bus4.a0 = 0; bus4.go_btn = 0;
    test_reset();
    test_display();
    test_halt_resume();
    test_simultaneous();
    test_debounce();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
